// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_VAL    = 3;

  // Largest magnitude representable in the given number of BCD digits (10^digits - 1).
  function automatic int unsigned bcd_max_val(input int unsigned digits);
    int unsigned v;
    v = 32'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 32'd10;
    end
    return v - 32'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble pre-shift correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] adj_c
);

  always_comb begin
    adj_c = digit_i;
    if (digit_i >= 4'(BCD_ADJ_THRESH)) begin
      adj_c = digit_i + 4'(BCD_ADJ_VAL);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with start/done handshake.
// Define BIN_TO_BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CAT_W   = BCD_W + IN_W;
  localparam int unsigned CNT_W   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned MAX_VAL = bcd_max_val(DIGITS);

  bcd_state_t         state_q, state_d;
  logic [IN_W-1:0]    bin_r_q, bin_r_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_r_q, ovf_r_d;
  logic               sign_r_q, sign_r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [IN_W-1:0]    mag_c;
  logic               sign_c;
  logic               ovf_c;
  logic [BCD_W-1:0]   adj_c;
  logic [CAT_W-1:0]   shifted_c;

`ifdef BIN_TO_BCD_SIGNED_EN
  assign sign_c = bin[IN_W-1];
  assign mag_c  = sign_c ? IN_W'(-bin) : bin;
`else
  assign sign_c = 1'b0;
  assign mag_c  = bin;
`endif

  assign ovf_c = 32'(mag_c) > MAX_VAL;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .adj_c   (adj_c[4*g +: 4])
    );
  end

  // Adjusted digits and remaining binary bits move left as one register; the top bit falls off.
  assign shifted_c = {adj_c, bin_r_q} << 1;

  always_comb begin
    state_d   = state_q;
    bin_r_d   = bin_r_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_r_d   = ovf_r_q;
    sign_r_d  = sign_r_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_r_d   = mag_c;
          scratch_d = '0;
          sign_r_d  = sign_c;
          ovf_r_d   = ovf_c;
          cnt_d     = CNT_W'(IN_W - 1);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted_c[CAT_W-1:IN_W];
        bin_r_d   = shifted_c[IN_W-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = ovf_r_q ? {DIGITS{4'h9}} : shifted_c[CAT_W-1:IN_W];
          neg_d   = sign_r_q;
          ovf_d   = ovf_r_q;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      bin_r_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_r_q   <= 1'b0;
      sign_r_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_r_q   <= bin_r_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_r_q   <= ovf_r_d;
      sign_r_q  <= sign_r_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: two-digit and one-digit instances against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int IN_W = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [IN_W-1:0] bin;

  logic       busy2, done2, neg2, ovf2;
  logic [7:0] bcd2;
  logic       busy1, done1, neg1, ovf1;
  logic [3:0] bcd1;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(2)) u_dut2 (
    .Clock(clk), .Resetn(rst_n), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .neg(neg2), .overflow(ovf2)
  );

  bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(1)) u_dut1 (
    .Clock(clk), .Resetn(rst_n), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .neg(neg1), .overflow(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from decimal arithmetic: sign, magnitude, saturate, split digits.
  function automatic void ref_conv(input logic [IN_W-1:0] v, input int digits,
                                   output logic [7:0] bcd_o, output logic neg_o,
                                   output logic ovf_o);
    int mag;
    int lim;
    mag   = int'(v);
    neg_o = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    if (v[IN_W-1]) begin
      neg_o = 1'b1;
      mag   = (1 << IN_W) - int'(v);
    end
`endif
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ovf_o = (mag > lim - 1);
    if (ovf_o) mag = lim - 1;
    bcd_o = 8'h00;
    for (int i = 0; i < digits; i++) begin
      bcd_o = bcd_o | 8'((mag % 10) << (4 * i));
      mag   = mag / 10;
    end
  endfunction

  // Transaction model: accept in idle, result visible IN_W edges later, idle again one edge after.
  int              phase;
  logic [IN_W-1:0] cap;
  logic            m_busy, m_done, m_neg, m_ovf2, m_ovf1;
  logic [7:0]      m_bcd2, m_bcd1w;
  logic            m_neg1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = -1; m_busy = 0; m_done = 0; m_neg = 0; m_ovf2 = 0; m_ovf1 = 0;
      m_bcd2 = 0; m_bcd1w = 0; m_neg1 = 0; cap = '0;
    end else if (phase < 0) begin
      if (start === 1'b1) begin
        cap    = bin;
        phase  = 0;
        m_busy = 1'b1;
      end
    end else begin
      phase = phase + 1;
      if (phase == IN_W) begin
        m_done = 1'b1;
        ref_conv(cap, 2, m_bcd2, m_neg, m_ovf2);
        ref_conv(cap, 1, m_bcd1w, m_neg1, m_ovf1);
      end else if (phase == IN_W + 1) begin
        m_done = 1'b0;
        m_busy = 1'b0;
        phase  = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("dut2 {busy,done,bcd,neg,ovf}", 32'({busy2, done2, bcd2, neg2, ovf2}),
            32'({m_busy, m_done, m_bcd2, m_neg, m_ovf2}));
      check("dut1 {busy,done,bcd,neg,ovf}", 32'({busy1, done1, bcd1, neg1, ovf1}),
            32'({m_busy, m_done, m_bcd1w[3:0], m_neg1, m_ovf1}));
    end
  end

  // One-cycle start, bounded wait for done, then check latency and result literals.
  task automatic run_conv(input logic [IN_W-1:0] v, input logic [7:0] exp_bcd, input logic exp_neg,
                          input bit chk1, input logic [3:0] exp_bcd1, input logic exp_ovf1);
    int  n;
    bit  got;
    n = 0; got = 0;
    start = 1'b1; bin = v;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("busy after accept", 32'(busy2), 32'(1));
      end
      if (done2) got = 1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL done timeout: got none expected done for bin=%0d", v);
    end else begin
      check("done latency", 32'(n), 32'(IN_W + 1));
      check("bcd literal", 32'(bcd2), 32'(exp_bcd));
      check("neg literal", 32'(neg2), 32'(exp_neg));
      check("overflow literal", 32'(ovf2), 32'(0));
      if (chk1) begin
        check("bcd1 literal", 32'(bcd1), 32'(exp_bcd1));
        check("overflow1 literal", 32'(ovf1), 32'(exp_ovf1));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output bit got);
    int n;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done2) got = 1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL done timeout: got none expected done");
    end
  endtask

  initial begin
    logic [7:0] pb;
    logic       pn, po;
    bit         got;
    int         done_seen;

    ref_conv(6'd41, 2, pb, pn, po);
`ifdef BIN_TO_BCD_SIGNED_EN
    check("model -23", 32'({pb, pn, po}), 32'({8'h23, 1'b1, 1'b0}));
    ref_conv(6'b100000, 2, pb, pn, po);
    check("model -32", 32'({pb, pn, po}), 32'({8'h32, 1'b1, 1'b0}));
`else
    check("model 41", 32'({pb, pn, po}), 32'({8'h41, 1'b0, 1'b0}));
    ref_conv(6'd63, 2, pb, pn, po);
    check("model 63", 32'({pb, pn, po}), 32'({8'h63, 1'b0, 1'b0}));
`endif
    ref_conv(6'd12, 1, pb, pn, po);
    check("model ovf 12", 32'({pb, po}), 32'({8'h09, 1'b1}));

    rst_n = 1'b1; start = 1'b1; bin = 6'd41;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({busy2, done2, bcd2, neg2, ovf2}), 32'(0));
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef BIN_TO_BCD_SIGNED_EN
    run_conv(6'b101100, 8'h20, 1'b1, 1'b0, 4'h0, 1'b0);
    run_conv(6'b100000, 8'h32, 1'b1, 1'b0, 4'h0, 1'b0);
    run_conv(6'd0,      8'h00, 1'b0, 1'b1, 4'h0, 1'b0);
    run_conv(6'd31,     8'h31, 1'b0, 1'b0, 4'h0, 1'b0);
`else
    run_conv(6'd41,     8'h41, 1'b0, 1'b0, 4'h0, 1'b0);
    run_conv(6'd0,      8'h00, 1'b0, 1'b1, 4'h0, 1'b0);
    run_conv(6'd63,     8'h63, 1'b0, 1'b1, 4'h9, 1'b1);
    run_conv(6'b101100, 8'h44, 1'b0, 1'b0, 4'h0, 1'b0);
`endif
    run_conv(6'd12, 8'h12, 1'b0, 1'b1, 4'h9, 1'b1);
    run_conv(6'd9,  8'h09, 1'b0, 1'b1, 4'h9, 1'b0);

    // start held through a conversion: second operand taken only after DONE
    start = 1'b1; bin = 6'd41;
    @(posedge clk); #1;
    bin = 6'd17;
    wait_done(got);
`ifdef BIN_TO_BCD_SIGNED_EN
    if (got) check("held start first", 32'({bcd2, neg2}), 32'({8'h23, 1'b1}));
`else
    if (got) check("held start first", 32'({bcd2, neg2}), 32'({8'h41, 1'b0}));
`endif
    wait_done(got);
    start = 1'b0;
    if (got) check("held start second", 32'({bcd2, neg2}), 32'({8'h17, 1'b0}));
    repeat (2) @(posedge clk);
    #1;

    // reset on the third SHIFT cycle
    start = 1'b1; bin = 6'd55;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", 32'({busy2, done2, bcd2, neg2, ovf2}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done2) done_seen++;
    end
    check("no done after reset", 32'(done_seen), 32'(0));
    run_conv(6'd9, 8'h09, 1'b0, 1'b1, 4'h9, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      bin   = IN_W'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
